// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and its ALU:
// opcodes, functs, ALU operation codes, FSM states and mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

endpackage

// File: rtl/alu_control_decoder.sv
// R-type funct to ALU operation map plus an unsupported-funct flag.
// Purely combinational, zero latency, no flow control.
module alu_control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_illegal
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_NOR:  alu_ctrl = ALU_NOR;
            default: funct_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS32 datapath; outputs decode from the state register.
// 2-5 cycles per instruction depending on class; no backpressure, one instruction in flight.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUcontrol,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic [3:0] funct_alu;
    logic       funct_bad;
    logic       decode_ok;

    alu_control_decoder u_alu_dec (
        .funct         (funct),
        .alu_ctrl      (funct_alu),
        .funct_illegal (funct_bad)
    );

    always_comb begin
        decode_ok = 1'b1;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: decode_ok = 1'b1;
            OP_RTYPE: decode_ok = ~funct_bad;
            default:  decode_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   state_d = MEMADR;
                    OP_RTYPE:       state_d = funct_bad ? FETCH : EXEC;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_ADDI:        state_d = ADDIEX;
                    OP_J:           state_d = JUMP;
                    default:        state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            EXEC:    state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUcontrol = ALU_ADD;
        PCSource   = PCSRC_ALU;
        illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                PCEn    = 1'b1;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                illegal = ~decode_ok;
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = funct_alu;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUcontrol = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCEn       = ((opcode == OP_BEQ) & Zero) | ((opcode == OP_BNE) & ~Zero);
            end
            JUMP: begin
                PCSource = PCSRC_JUMP;
                PCEn     = 1'b1;
            end
            default: ;
        endcase
        // State is already FETCH under reset; only the side-effecting enables need masking.
        if (!rst_n) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized bench for mips_multicycle_control with an instruction-level reference model.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       Zero;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
    logic       ALUSrcA, illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUcontrol, state_o;

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUcontrol(ALUcontrol),
        .PCSource(PCSource), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    int fn_tab[6]   = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h27};
    int code_tab[6] = '{2, 6, 0, 1, 7, 12};

    function automatic int funct_index(input logic [5:0] fn);
        int idx = -1;
        for (int i = 0; i < 6; i++) if (fn_tab[i] == int'(fn)) idx = i;
        return idx;
    endfunction

    // Sequence of states visited by one instruction, from FETCH onward.
    function automatic int path_len(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23:        return 5;
            6'h2B:        return 4;
            6'h00:        return (funct_index(fn) >= 0) ? 4 : 2;
            6'h08:        return 4;
            6'h04, 6'h05: return 3;
            6'h02:        return 3;
            default:      return 2;
        endcase
    endfunction

    function automatic int path_state(input logic [5:0] op, input logic [5:0] fn, input int step);
        int lw_p[5]   = '{0, 1, 2, 3, 4};
        int sw_p[4]   = '{0, 1, 2, 5};
        int r_p[4]    = '{0, 1, 6, 7};
        int ad_p[4]   = '{0, 1, 9, 10};
        if (step < 2) return step;
        case (op)
            6'h23:        return lw_p[step];
            6'h2B:        return sw_p[step];
            6'h00:        return r_p[step];
            6'h08:        return ad_p[step];
            6'h04, 6'h05: return 8;
            default:      return 11;
        endcase
    endfunction

    // Expected output vector {PCEn,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
    // ALUSrcA,ALUSrcB[1:0],ALUcontrol[3:0],PCSource[1:0],illegal} for a given state.
    function automatic logic [17:0] model_vec(input int st, input logic [5:0] op,
                                              input logic [5:0] fn, input logic z);
        logic pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ill;
        logic [1:0] srcb, pcs;
        logic [3:0] alu;
        pcen = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0; rdst = 0; rw = 0;
        srca = 0; ill = 0; srcb = 2'b00; pcs = 2'b00; alu = 4'b0010;
        case (st)
            0:  begin mrd = 1; irw = 1; srcb = 2'b01; pcen = 1; end
            1:  begin srcb = 2'b11; ill = (path_len(op, fn) == 2); end
            2, 9: begin srca = 1; srcb = 2'b10; end
            3:  begin iord = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mwr = 1; end
            6:  begin srca = 1; alu = code_tab[funct_index(fn)][3:0]; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; alu = 4'b0110; pcs = 2'b01; pcen = (op == 6'h04) ? z : ~z; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {pcen, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, alu, pcs, ill};
    endfunction

    logic check_en = 1'b0;
    int   exp_state = 0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle_state", {28'd0, state_o}, exp_state);
            chk("cycle_outputs",
                {PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                 ALUSrcA, ALUSrcB, ALUcontrol, PCSource, illegal},
                model_vec(exp_state, opcode, funct, Zero));
        end
    end

    int obs_states[$];
    int cnt_m2r_rw, cnt_rw, cnt_mw, cnt_ill;
    int exec_alu, wb_rdst, br_pcen, br_pcs;

    // Runs one instruction; called at posedge+1 of its FETCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input int stop_at);
        int n = path_len(op, fn);
        obs_states.delete();
        cnt_m2r_rw = 0; cnt_rw = 0; cnt_mw = 0; cnt_ill = 0;
        exec_alu = -1; wb_rdst = -1; br_pcen = -1; br_pcs = -1;
        check_en = 1'b1;
        for (int s = 0; s < n; s++) begin
            exp_state = path_state(op, fn, s);
            if (exp_state == 1) begin opcode = op; funct = fn; end
            Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            obs_states.push_back(int'(state_o));
            cnt_m2r_rw += int'(MemtoReg & RegWrite);
            cnt_rw     += int'(RegWrite);
            cnt_mw     += int'(MemWrite);
            cnt_ill    += int'(illegal);
            if (state_o == 4'd6) exec_alu = int'(ALUcontrol);
            if (state_o == 4'd7) wb_rdst  = int'(RegDst & RegWrite);
            if (state_o == 4'd8) begin br_pcen = int'(PCEn); br_pcs = int'(PCSource); end
            if (s == stop_at) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic pick(output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] ops[7] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h05, 6'h02};
        int r = $urandom_range(0, 9);
        fn = 6'($urandom);
        if (r < 7) op = ops[r];
        else       op = (r == 9) ? 6'h00 : 6'($urandom);
        if (op == 6'h00 && r != 9) fn = fn_tab[$urandom_range(0, 5)][5:0];
    endtask

    initial begin
        logic [5:0] op, fn;
        rst_n = 1'b0; opcode = 6'h00; funct = 6'h20; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {28'd0, state_o}, 0);
        chk("rst_pcen", {31'd0, PCEn}, 0);
        chk("rst_irwrite", {31'd0, IRWrite}, 0);
        chk("rst_memread", {31'd0, MemRead}, 0);
        chk("rst_alusrcb", {30'd0, ALUSrcB}, 1);
        rst_n = 1'b1;
        #1;
        chk("rel_pcen", {31'd0, PCEn}, 1);
        chk("rel_irwrite", {31'd0, IRWrite}, 1);
        chk("rel_memread", {31'd0, MemRead}, 1);

        run_instr(6'h23, 6'h00, 2, -1);
        chk("lw_len", obs_states.size(), 5);
        for (int i = 0; i < 5 && i < obs_states.size(); i++) chk("lw_seq", obs_states[i], i);
        chk("lw_memwb_once", cnt_m2r_rw, 1);
        chk("lw_no_memwrite", cnt_mw, 0);

        for (int k = 0; k < 6; k++) begin
            run_instr(6'h00, fn_tab[k][5:0], 2, -1);
            chk("rtype_alu", exec_alu, code_tab[k]);
            chk("rtype_wb", wb_rdst, 1);
        end

        run_instr(6'h04, 6'h00, 1, -1);
        chk("beq_z1_pcen", br_pcen, 1);
        chk("beq_z1_pcsrc", br_pcs, 1);
        run_instr(6'h04, 6'h00, 0, -1);
        chk("beq_z0_pcen", br_pcen, 0);
        run_instr(6'h05, 6'h00, 1, -1);
        chk("bne_z1_pcen", br_pcen, 0);
        run_instr(6'h05, 6'h00, 0, -1);
        chk("bne_z0_pcen", br_pcen, 1);

        run_instr(6'h3F, 6'h20, 2, -1);
        chk("ill_op_pulse", cnt_ill, 1);
        chk("ill_op_len", obs_states.size(), 2);
        chk("ill_op_nowrite", cnt_rw + cnt_mw, 0);
        run_instr(6'h00, 6'h00, 2, -1);
        chk("ill_fn_pulse", cnt_ill, 1);
        chk("ill_fn_len", obs_states.size(), 2);
        chk("ill_fn_nowrite", cnt_rw + cnt_mw, 0);

        // lw interrupted by reset while in MEMRD
        run_instr(6'h23, 6'h00, 2, 3);
        chk("mid_memrd_state", {28'd0, state_o}, 3);
        #2;
        check_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {28'd0, state_o}, 0);
        chk("mid_rst_memread", {31'd0, MemRead}, 0);
        chk("mid_rst_regwrite", {31'd0, RegWrite}, 0);
        @(posedge clk); #1;
        chk("mid_rst_hold_state", {28'd0, state_o}, 0);
        chk("mid_rst_no_memwb", {31'd0, RegWrite | MemtoReg}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (200) begin
            pick(op, fn);
            run_instr(op, fn, 2, -1);
        end
        check_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS32 datapath. It sits directly upstream of the ALU: from the instruction register's opcode and funct fields it sequences each instruction through a Moore state machine. Every cycle it drives the datapath enables, the multiplexer selects and the 4-bit ALU operation code, and it uses the ALU's Zero flag to resolve branches.

## Interface
Parameters: none.

Ports:
- clk — in — 1 — single clock; state updates on the rising edge.
- rst_n — in — 1 — reset, asynchronous, active-low.
- opcode — in — 6 — IR[31:26]; stable except on cycles after IRWrite.
- funct — in — 6 — IR[5:0].
- Zero — in — 1 — ALU result-equals-zero flag, combinational from the ALU.
- PCEn — out — 1 — PC load enable.
- IorD — out — 1 — memory address select: 0 = PC, 1 = ALUOut.
- MemRead — out — 1 — memory read enable.
- MemWrite — out — 1 — memory write enable.
- IRWrite — out — 1 — instruction register load enable.
- MemtoReg — out — 1 — register write-data select: 0 = ALUOut, 1 = MDR.
- RegDst — out — 1 — destination register select: 0 = rt, 1 = rd.
- RegWrite — out — 1 — register file write enable.
- ALUSrcA — out — 1 — ALU A select: 0 = PC, 1 = register A.
- ALUSrcB — out — 2 — ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- ALUcontrol — out — 4 — ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- PCSource — out — 2 — PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal — out — 1 — one-cycle pulse on an unsupported opcode or funct.
- state_o — out — 4 — current state, for debug.

## Operation
State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and return to FETCH.

Transitions:
- FETCH → DECODE.
- DECODE → one of:
  - MEMADR for lw (0x23) or sw (0x2B).
  - EXEC for R-type (0x00) with a legal funct.
  - BRANCH for beq (0x04) or bne (0x05).
  - ADDIEX for addi (0x08).
  - JUMP for j (0x02).
  - Otherwise FETCH, with illegal=1 during DECODE.
- MEMADR → MEMRD for lw, MEMWR for sw.
- MEMRD → MEMWB.
- EXEC → ALUWB.
- ADDIEX → ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.

Legal R-type funct values and their ALUcontrol codes: 0x20 add → 0010, 0x22 sub → 0110, 0x24 and → 0000, 0x25 or → 0001, 0x2A slt → 0111, 0x27 nor → 1100. Any other funct is illegal and handled in DECODE as above.

Outputs per state (anything not listed is 0; ALUcontrol defaults to 0010):
- FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALU add, PCSource=00, PCEn=1.
- DECODE: ALUSrcB=11, ALU add (computes the branch target).
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU add.
- MEMRD: IorD=1, MemRead=1.
- MEMWR: IorD=1, MemWrite=1.
- MEMWB: MemtoReg=1, RegWrite=1.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUcontrol decoded from funct.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALU sub, PCSource=01, PCEn=(beq & Zero) | (bne & ~Zero).
- JUMP: PCSource=10, PCEn=1.

## Timing
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- All outputs decode combinationally from the state register. The only exceptions: PCEn in BRANCH also depends on Zero and opcode, ALUcontrol in EXEC depends on funct, and illegal in DECODE depends on opcode and funct. There is no registered output stage.
- Reset:
  - Asserting rst_n low forces the state to FETCH immediately, at any point in an instruction.
  - While rst_n is low, PCEn, IRWrite, MemRead, MemWrite, RegWrite and illegal are forced to 0; all other outputs take their FETCH values.
  - The first FETCH with writes enabled is the first rising edge after rst_n deasserts.
- Reset mid-instruction abandons the instruction; no further RegWrite or MemWrite is issued for it.
- opcode and funct must not change except in the cycle after FETCH. The unit relies on this and does not latch them.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants;
  - funct constants;
  - ALUcontrol codes, shared with the ALU;
  - the state enum;
  - ALUSrcB and PCSource select encodings.
- Sub-module alu_control_decoder (combinational) maps funct to ALUcontrol and a funct-illegal flag. It is instantiated once and reused for the DECODE legality check.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → state_o=0, PCEn=IRWrite=0. At the first edge after release → PCEn=1, IRWrite=1, MemRead=1.
- lw (opcode 0x23): state_o sequence 0,1,2,3,4. MemtoReg=1 and RegWrite=1 in exactly one cycle (MEMWB). MemWrite never asserts.
- R-type sub (funct 0x22): ALUcontrol=0110 in EXEC, RegDst=1 and RegWrite=1 in ALUWB. Repeat for each of the six legal functs and check the codes.
- beq with Zero=1 → PCEn=1 and PCSource=01 in BRANCH. beq with Zero=0 → PCEn=0. bne gives the inverse result.
- Illegal opcode 0x3F → illegal pulses for one cycle in DECODE, next state FETCH, no RegWrite or MemWrite. R-type with funct 0x00 behaves the same.
- Reset pulse during MEMRD of lw → state_o=0 immediately, MemRead=0 while reset is low, and no MEMWB RegWrite follows.
